// File: rtl/oam_dma.sv
// OAM DMA engine: a CPU write to DMA_REG_ADDR copies OAM_LEN bytes from page {data,8'h00} into OAM.
// Optional macro OAM_DMA_CPU_BLOCK_EN enables oCpuBlock; otherwise oCpuBlock is tied low.
module oam_dma #(
  parameter int          OAM_LEN      = 160,
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        iCpuWe,
  input  logic [15:0] iCpuAddr,
  input  logic [7:0]  iCpuData,
  output logic        oDmaReadRequest,
  output logic [15:0] oDmaReadAddr,
  input  logic [7:0]  iDmaReadData,
  output logic        oOamWe,
  output logic [7:0]  oOamAddr,
  output logic [7:0]  oOamData,
  output logic        oDmaBusy,
  output logic        oCpuBlock,
  output logic [7:0]  oDmaReg
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_XFER  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(OAM_LEN - 1);

  state_t     state_q, state_d;
  logic [7:0] page_q, page_d;
  logic [7:0] count_q, count_d;
  logic [7:0] reg_q, reg_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic       wr_pend_q, wr_pend_d;
  logic       trigger_s;

  // Echo RAM (E0..FF) aliases work RAM (C0..DF).
  function automatic logic [7:0] fold_page(input logic [7:0] p);
    if (p[7:5] == 3'b111) begin
      return p & 8'hDF;
    end else begin
      return p;
    end
  endfunction

  assign trigger_s = iCpuWe && (iCpuAddr == DMA_REG_ADDR);

  // Next-state logic; a trigger in any state restarts the transfer and drops the pending write.
  always_comb begin
    state_d   = state_q;
    page_d    = page_q;
    count_d   = count_q;
    reg_d     = reg_q;
    wr_addr_d = count_q;
    wr_pend_d = 1'b0;
    if (trigger_s) begin
      reg_d   = iCpuData;
      page_d  = fold_page(iCpuData);
      count_d = 8'h00;
      state_d = ST_SETUP;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_SETUP: begin
          state_d = ST_XFER;
        end
        ST_XFER: begin
          wr_pend_d = 1'b1;
          count_d   = count_q + 8'd1;
          if (count_q == LAST_IDX) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_XFER;
          end
        end
        ST_DRAIN: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State, counter and write-pipeline registers with synchronous reset.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q   <= ST_IDLE;
      page_q    <= 8'h00;
      count_q   <= 8'h00;
      reg_q     <= 8'h00;
      wr_addr_q <= 8'h00;
      wr_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      page_q    <= page_d;
      count_q   <= count_d;
      reg_q     <= reg_d;
      wr_addr_q <= wr_addr_d;
      wr_pend_q <= wr_pend_d;
    end
  end

  assign oDmaReadRequest = (state_q == ST_XFER);
  assign oDmaReadAddr    = {page_q, count_q};
  assign oOamWe          = wr_pend_q;
  assign oOamAddr        = wr_addr_q;
  assign oOamData        = iDmaReadData;
  assign oDmaBusy        = (state_q != ST_IDLE);
  assign oDmaReg         = reg_q;

`ifdef OAM_DMA_CPU_BLOCK_EN
  logic in_hram_s;
  assign in_hram_s = (iCpuAddr >= 16'hFF80) && (iCpuAddr <= 16'hFFFE);
  // HRAM stays reachable and the DMA register itself is never blocked so the CPU can re-trigger.
  assign oCpuBlock = oDmaBusy && !in_hram_s && (iCpuAddr != DMA_REG_ADDR);
`else
  assign oCpuBlock = 1'b0;
`endif

endmodule

// File: tb/tb_oam_dma.sv
// Scoreboard bench for oam_dma: stimulus pushes expected reads/OAM writes, a negedge monitor pops and compares.
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        rd_req;
  logic [15:0] rd_addr;
  logic [7:0]  rd_data = 8'h00;
  logic        oam_we;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_data;
  logic        busy;
  logic        cpu_block;
  logic [7:0]  dma_reg;

  int errors = 0;
  int checks = 0;
  int busy_cnt = 0;
  logic [15:0] rd_q[$];
  logic [15:0] wr_q[$];

`ifdef OAM_DMA_CPU_BLOCK_EN
  localparam logic EXP_BLK = 1'b1;
`else
  localparam logic EXP_BLK = 1'b0;
`endif

  always #5 clk = ~clk;

  oam_dma #(.OAM_LEN(160), .DMA_REG_ADDR(16'hFF46)) dut (
    .iClock(clk), .iReset(rst), .iCpuWe(cpu_we), .iCpuAddr(cpu_addr), .iCpuData(cpu_data),
    .oDmaReadRequest(rd_req), .oDmaReadAddr(rd_addr), .iDmaReadData(rd_data),
    .oOamWe(oam_we), .oOamAddr(oam_addr), .oOamData(oam_data),
    .oDmaBusy(busy), .oCpuBlock(cpu_block), .oDmaReg(dma_reg)
  );

  // Source memory contents as seen by the bench.
  function automatic logic [7:0] src(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
  endfunction

  // Source memory responds one cycle after a read strobe.
  always @(posedge clk) begin
    if (rd_req) rd_data <= src(rd_addr);
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: counts busy cycles and pops the scoreboard on every strobe.
  always @(negedge clk) begin
    if (busy === 1'b1) busy_cnt++;
    if (rd_req === 1'b1) begin
      if (rd_q.size() == 0) check("unexpected_read", rd_addr, 16'hFFFF);
      else check("read_addr", rd_addr, rd_q.pop_front());
    end
    if (oam_we === 1'b1) begin
      checks++;
      if (oam_addr >= 8'd160) begin
        errors++;
        $display("FAIL oam_addr_range: got %0d required below 160", oam_addr);
      end
      if (wr_q.size() == 0) check("unexpected_oam_write", {oam_addr, oam_data}, 16'hFFFF);
      else check("oam_write", {oam_addr, oam_data}, wr_q.pop_front());
    end
  end

  // Called at posedge+1; drives the trigger this cycle and loads the scoreboard after it is sampled.
  task automatic trigger(input logic [7:0] d, input logic [7:0] page);
    cpu_we = 1'b1; cpu_addr = 16'hFF46; cpu_data = d;
    #1 check("no_block_on_dma_reg", {15'd0, cpu_block}, 16'd0);
    @(posedge clk); #1;
    cpu_we = 1'b0; cpu_addr = 16'h0000;
    rd_q.delete(); wr_q.delete(); busy_cnt = 0;
    for (int i = 0; i < 160; i++) begin
      rd_q.push_back({page, 8'(i)});
      wr_q.push_back({8'(i), src({page, 8'(i)})});
    end
    check("dma_reg", {8'h00, dma_reg}, {8'h00, d});
    check("busy_setup", {15'd0, busy}, 16'd1);
  endtask

  task automatic wait_read_byte(input logic [7:0] n);
    bit found = 1'b0;
    for (int c = 0; c < 400 && !found; c++) begin
      if (rd_req === 1'b1 && rd_addr[7:0] == n) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("wait_read_byte_timeout", {15'd0, found}, 16'd1);
  endtask

  task automatic wait_done();
    bit done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      if (busy === 1'b0) done = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("wait_done_timeout", {15'd0, done}, 16'd1);
    check("busy_cycles", 16'(busy_cnt), 16'd162);
    check("reads_left", 16'(rd_q.size()), 16'd0);
    check("writes_left", 16'(wr_q.size()), 16'd0);
  endtask

  initial begin
    rst = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_oam_we", {15'd0, oam_we}, 16'd0);
    check("rst_rd_req", {15'd0, rd_req}, 16'd0);
    check("rst_dma_reg", {8'h00, dma_reg}, 16'h0000);
    check("rst_cpu_block", {15'd0, cpu_block}, 16'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Full transfer from C000 with CPU-block probes mid-transfer.
    trigger(8'hC0, 8'hC0);
    repeat (5) begin @(posedge clk); #1; end
    cpu_addr = 16'hC123;
    #1 check("block_c123_busy", {15'd0, cpu_block}, {15'd0, EXP_BLK});
    cpu_addr = 16'hFF85;
    #1 check("block_ff85_busy", {15'd0, cpu_block}, 16'd0);
    cpu_addr = 16'h0000;
    wait_done();
    cpu_addr = 16'hC123;
    #1 check("block_c123_idle", {15'd0, cpu_block}, 16'd0);
    check("dma_reg_after_c0", {8'h00, dma_reg}, 16'h00C0);
    cpu_addr = 16'h0000;

    // Echo page folds to work RAM.
    @(posedge clk); #1;
    trigger(8'hE1, 8'hC1);
    wait_done();
    check("dma_reg_after_e1", {8'h00, dma_reg}, 16'h00E1);

    // Re-trigger at byte 50 with page D0.
    @(posedge clk); #1;
    trigger(8'hC0, 8'hC0);
    wait_read_byte(8'd50);
    trigger(8'hD0, 8'hD0);
    wait_done();

    // Reset pulse at byte 80.
    @(posedge clk); #1;
    trigger(8'h45, 8'h45);
    wait_read_byte(8'd80);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    rd_q.delete(); wr_q.delete();
    check("abort_busy", {15'd0, busy}, 16'd0);
    check("abort_oam_we", {15'd0, oam_we}, 16'd0);
    check("abort_dma_reg", {8'h00, dma_reg}, 16'h0000);
    repeat (20) begin @(posedge clk); #1; end
    check("abort_still_idle", {15'd0, busy}, 16'd0);

    // Reset wins over a simultaneous trigger.
    rst = 1'b1; cpu_we = 1'b1; cpu_addr = 16'hFF46; cpu_data = 8'h77;
    @(posedge clk); #1;
    rst = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000;
    check("rst_prio_busy", {15'd0, busy}, 16'd0);
    check("rst_prio_dma_reg", {8'h00, dma_reg}, 16'h0000);
    repeat (5) begin @(posedge clk); #1; end
    check("rst_prio_idle", {15'd0, busy}, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
